// File: rtl/sram_mem_controller.sv
// Memory-stage controller: splits one 32-bit load/store into two 16-bit phases
// on an asynchronous SRAM and stalls the pipeline through ready until it completes.
module sram_mem_controller #(
    parameter logic [31:0] BASE_ADDR    = 32'd1024,
    parameter int          PHASE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic        sram_we_n,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in
);

    typedef enum logic [2:0] {
        IDLE,
        WR_LO,
        WR_HI,
        RD_LO,
        RD_HI,
        DONE
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(PHASE_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] wdata_hi_q, wdata_hi_d;
    logic [31:0] read_data_q, read_data_d;
    logic [17:0] sram_addr_q, sram_addr_d;
    logic [15:0] dq_out_q, dq_out_d;

    logic [31:0] off;
    logic [16:0] req_word;
    logic        phase_last;
    logic        unused_off_bits;

    assign off             = address - BASE_ADDR;
    assign req_word        = off[18:2];
    assign unused_off_bits = ^{off[31:19], off[1:0]};
    assign phase_last      = (cnt_q == LAST_CNT);

    // The high-half address reuses the word index already on the pins from the low phase.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wdata_hi_d  = wdata_hi_q;
        read_data_d = read_data_q;
        sram_addr_d = sram_addr_q;
        dq_out_d    = dq_out_q;

        case (state_q)
            IDLE: begin
                cnt_d = 4'd0;
                if (wr_en) begin
                    state_d     = WR_LO;
                    wdata_hi_d  = write_data[31:16];
                    sram_addr_d = {req_word, 1'b0};
                    dq_out_d    = write_data[15:0];
                end else if (rd_en) begin
                    state_d     = RD_LO;
                    sram_addr_d = {req_word, 1'b0};
                end
            end
            WR_LO: begin
                if (phase_last) begin
                    state_d     = WR_HI;
                    cnt_d       = 4'd0;
                    sram_addr_d = {sram_addr_q[17:1], 1'b1};
                    dq_out_d    = wdata_hi_q;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            WR_HI: begin
                if (phase_last) begin
                    state_d = DONE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RD_LO: begin
                if (phase_last) begin
                    state_d           = RD_HI;
                    cnt_d             = 4'd0;
                    sram_addr_d       = {sram_addr_q[17:1], 1'b1};
                    read_data_d[15:0] = sram_dq_in;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RD_HI: begin
                if (phase_last) begin
                    state_d            = DONE;
                    cnt_d              = 4'd0;
                    read_data_d[31:16] = sram_dq_in;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            wdata_hi_q  <= 16'd0;
            read_data_q <= 32'd0;
            sram_addr_q <= 18'd0;
            dq_out_q    <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wdata_hi_q  <= wdata_hi_d;
            read_data_q <= read_data_d;
            sram_addr_q <= sram_addr_d;
            dq_out_q    <= dq_out_d;
        end
    end

    // Strobes decode straight from the state register so reset releases the pads at once.
    assign sram_we_n   = !((state_q == WR_LO) || (state_q == WR_HI));
    assign sram_dq_oe  = (state_q == WR_LO) || (state_q == WR_HI);
    assign sram_dq_out = dq_out_q;
    assign sram_addr   = sram_addr_q;
    assign read_data   = read_data_q;
    assign ready       = (state_q == DONE) || ((state_q == IDLE) && !(rd_en || wr_en));

endmodule

// File: tb/tb_sram_mem_controller.sv
// Bench for sram_mem_controller: directed vector table, multi-cycle corner sequences
// and randomized accesses checked against a half-word memory model.
module tb_sram_mem_controller;

    localparam int PC  = 2;
    localparam int LAT = 2 * PC + 1;

    logic        clk;
    logic        rst;
    logic        rd_en, wr_en;
    logic [31:0] address, write_data, read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic        sram_we_n;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic        sram_dq_oe;

    logic        rd_en1, wr_en1;
    logic [31:0] address1, write_data1, read_data1;
    logic        ready1;
    logic [17:0] sram_addr1;
    logic        sram_we_n1;
    logic [15:0] sram_dq_out1, sram_dq_in1;
    logic        sram_dq_oe1;
    logic        unused_sink;

    int tests_run;
    int tests_failed;

    sram_mem_controller #(.BASE_ADDR(32'd1024), .PHASE_CYCLES(PC)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
        .write_data(write_data), .read_data(read_data), .ready(ready),
        .sram_addr(sram_addr), .sram_we_n(sram_we_n), .sram_dq_out(sram_dq_out),
        .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in)
    );

    sram_mem_controller #(.BASE_ADDR(32'd1024), .PHASE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .rd_en(rd_en1), .wr_en(wr_en1), .address(address1),
        .write_data(write_data1), .read_data(read_data1), .ready(ready1),
        .sram_addr(sram_addr1), .sram_we_n(sram_we_n1), .sram_dq_out(sram_dq_out1),
        .sram_dq_oe(sram_dq_oe1), .sram_dq_in(sram_dq_in1)
    );

    assign unused_sink = ^sram_dq_out1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous SRAM for the main instance, with a backdoor preload port.
    bit   [15:0] sram_mem [262144];
    logic        poke_en;
    logic [17:0] poke_addr;
    logic [15:0] poke_data;

    always @(posedge clk) begin
        if (poke_en) sram_mem[poke_addr] <= poke_data;
        else if (!sram_we_n) sram_mem[sram_addr] <= sram_dq_out;
    end
    assign sram_dq_in  = sram_mem[sram_addr];
    assign sram_dq_in1 = sram_addr1[15:0] ^ 16'h5A5A;

    // Reference model: half-word contents and the last completed load result.
    bit   [15:0] ref_mem [int];
    logic [31:0] exp_rdata;

    function automatic logic [15:0] ref_read(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
    endfunction

    function automatic int hw_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - 32'd1024;
        return int'((off / 32'd4) % 32'd131072) * 2;
    endfunction

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_rdata;
        logic [17:0] exp_hw;
    } vec_t;

    vec_t vecs [7];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data);
        rd_en      = rd;
        wr_en      = wr;
        address    = addr;
        write_data = data;
    endtask

    task automatic poke(input logic [17:0] a, input logic [15:0] d);
        poke_en   = 1'b1;
        poke_addr = a;
        poke_data = d;
        @(posedge clk);
        #1;
        poke_en = 1'b0;
    endtask

    // Runs one access starting in an IDLE cycle (called 1 time unit after a rising edge).
    task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data,
                              input logic [17:0] hw_lo, input logic [31:0] exp_rd, input string tag);
        int   rc;
        logic done;
        rc   = -1;
        done = 1'b0;
        applyStimulus(rd, wr, addr, data);
        for (int k = 0; k <= LAT + 3 && !done; k++) begin
            @(negedge clk);
            if (k == 0) begin
                checkOutput({tag, ".accept_we_n"}, 32'(sram_we_n), 32'd1);
            end else if (k <= 2 * PC) begin
                checkOutput({tag, ".addr"}, 32'(sram_addr), 32'((k <= PC) ? hw_lo : hw_lo + 18'd1));
                checkOutput({tag, ".we_n"}, 32'(sram_we_n), wr ? 32'd0 : 32'd1);
                checkOutput({tag, ".oe"}, 32'(sram_dq_oe), wr ? 32'd1 : 32'd0);
                if (wr)
                    checkOutput({tag, ".dq"}, 32'(sram_dq_out), 32'((k <= PC) ? data[15:0] : data[31:16]));
            end
            if (ready) begin
                rc   = k;
                done = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                applyStimulus(1'b0, 1'b0, $urandom, $urandom);
            end
        end
        checkOutput({tag, ".ready_cycle"}, 32'(rc), 32'(LAT));
        checkOutput({tag, ".rdata"}, read_data, exp_rd);
        checkOutput({tag, ".done_we_n"}, 32'(sram_we_n), 32'd1);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          rdy [12];
        int          j, op, hw;
        logic [31:0] a, d, ev;

        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        poke_en      = 1'b0;
        poke_addr    = 18'd0;
        poke_data    = 16'd0;
        rd_en1       = 1'b0;
        wr_en1       = 1'b0;
        address1     = 32'd0;
        write_data1  = 32'd0;
        exp_rdata    = 32'd0;
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);

        #1;
        checkOutput("reset.ready", 32'(ready), 32'd1);
        checkOutput("reset.we_n", 32'(sram_we_n), 32'd1);
        checkOutput("reset.oe", 32'(sram_dq_oe), 32'd0);
        checkOutput("reset.rdata", read_data, 32'd0);
        checkOutput("reset.addr", 32'(sram_addr), 32'd0);
        checkOutput("reset.dq", 32'(sram_dq_out), 32'd0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        poke(18'd2, 16'h1234);
        poke(18'd3, 16'hABCD);
        ref_mem[2] = 16'h1234;
        ref_mem[3] = 16'hABCD;

        vecs[0] = '{1'b0, 1'b1, 32'd1024,       32'hDEADBEEF, 32'h00000000, 18'h00000};
        vecs[1] = '{1'b1, 1'b0, 32'd1028,       32'h00000000, 32'hABCD1234, 18'h00002};
        vecs[2] = '{1'b1, 1'b0, 32'd1024,       32'h00000000, 32'hDEADBEEF, 18'h00000};
        vecs[3] = '{1'b1, 1'b1, 32'd1020,       32'h13579BDF, 32'hDEADBEEF, 18'h3FFFE};
        vecs[4] = '{1'b1, 1'b0, 32'd1020,       32'h00000000, 32'h13579BDF, 18'h3FFFE};
        vecs[5] = '{1'b0, 1'b1, 32'h0010040B,   32'h0BADF00D, 32'h13579BDF, 18'h00004};
        vecs[6] = '{1'b1, 1'b0, 32'd1032,       32'h00000000, 32'h0BADF00D, 18'h00004};

        for (int i = 0; i < 7; i++) begin
            run_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].exp_hw,
                       vecs[i].exp_rdata, $sformatf("vec%0d", i));
            if (vecs[i].wr) begin
                ref_mem[int'(vecs[i].exp_hw)]     = vecs[i].data[15:0];
                ref_mem[int'(vecs[i].exp_hw) + 1] = vecs[i].data[31:16];
            end
            exp_rdata = vecs[i].exp_rdata;
        end

        // Store 5 to 1032, then a load held on rd_en from the second cycle onward.
        applyStimulus(1'b0, 1'b1, 32'd1032, 32'd5);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            rdy[k] = int'(ready);
            if (k == 11) checkOutput("b2b.rdata", read_data, 32'd5);
            @(posedge clk);
            #1;
            if (k == 0) applyStimulus(1'b1, 1'b0, 32'd1032, 32'd0);
            if (k == 11) applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        end
        for (int k = 0; k < 12; k++)
            checkOutput($sformatf("b2b.ready_c%0d", k), 32'(rdy[k]), (k == LAT || k == 2 * LAT + 1) ? 32'd1 : 32'd0);
        ref_mem[4] = 16'd5;
        ref_mem[5] = 16'd0;
        exp_rdata  = 32'd5;

        // Asynchronous reset in the middle of the high write phase.
        applyStimulus(1'b0, 1'b1, 32'd1040, 32'hCAFEF00D);
        @(negedge clk);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        checkOutput("rstmid.pre_we_n", 32'(sram_we_n), 32'd0);
        checkOutput("rstmid.pre_addr", 32'(sram_addr), 32'd9);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("rstmid.we_n", 32'(sram_we_n), 32'd1);
        checkOutput("rstmid.oe", 32'(sram_dq_oe), 32'd0);
        checkOutput("rstmid.rdata", read_data, 32'd0);
        checkOutput("rstmid.addr", 32'(sram_addr), 32'd0);
        checkOutput("rstmid.dq", 32'(sram_dq_out), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rstmid.after_ready", 32'(ready), 32'd1);
        checkOutput("rstmid.after_we_n", 32'(sram_we_n), 32'd1);
        @(posedge clk);
        #1;
        ref_mem[8] = 16'hF00D;
        exp_rdata  = 32'd0;

        // Single-cycle phase build: a load of 1028 finishes in cycle 3.
        rd_en1   = 1'b1;
        address1 = 32'd1028;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput($sformatf("pc1.ready_c%0d", k), 32'(ready1), (k == 3) ? 32'd1 : 32'd0);
            checkOutput($sformatf("pc1.we_n_c%0d", k), 32'(sram_we_n1), 32'd1);
            checkOutput($sformatf("pc1.oe_c%0d", k), 32'(sram_dq_oe1), 32'd0);
            if (k == 1) checkOutput("pc1.addr_lo", 32'(sram_addr1), 32'd2);
            if (k == 2) checkOutput("pc1.addr_hi", 32'(sram_addr1), 32'd3);
            if (k == 3) checkOutput("pc1.rdata", read_data1, 32'h5A595A58);
            @(posedge clk);
            #1;
            rd_en1   = 1'b0;
            address1 = $urandom;
        end

        // Randomized loads, stores and simultaneous requests against the model.
        for (int i = 0; i < 40; i++) begin
            j  = int'($urandom_range(0, 15)) - 2;
            a  = 32'(1024 + 4 * j) + 32'($urandom_range(0, 3)) + 32'($urandom_range(0, 3)) * 32'h0008_0000;
            d  = $urandom;
            op = int'($urandom_range(0, 2));
            hw = hw_of(a);
            if (op == 0) ev = {ref_read(hw + 1), ref_read(hw)};
            else         ev = exp_rdata;
            run_access(op != 1, op != 0, a, d, 18'(hw), ev, $sformatf("rnd%0d", i));
            if (op != 0) begin
                ref_mem[hw]     = d[15:0];
                ref_mem[hw + 1] = d[31:16];
            end else begin
                exp_rdata = ev;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
